aes_req_scheduler: RTL and testbench
====================================

Name: aes_req_scheduler

Overview:
- Shares one fully pipelined AES-128 encryption core between two requesters (port 0, port 1).
- Round-robin arbitration issues at most one plaintext/key pair into the core per cycle.
- Tags every issued block with its requester ID in a valid/ID shift pipeline that matches the core latency.
- Returns each ciphertext with the ID of the requester that issued it; sits between the requester logic and the core.

Parameters:
- LATENCY, 21, core latency in cycles from core_state/core_key presented to core_out valid.
- CNT_W, 5, width of the in-flight counter; must satisfy 2^CNT_W > LATENCY+1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a block
- req0_ready  out  1  requester 0 block accepted this cycle
- req0_state  in  128  requester 0 plaintext
- req0_key  in  128  requester 0 key
- req1_valid, req1_ready, req1_state, req1_key: same as port 0, for requester 1
- core_state  out  128  registered plaintext to core
- core_key  out  128  registered key to core
- core_out  in  128  ciphertext from core
- res_valid  out  1  res_data valid this cycle
- res_id  out  1  requester that owns res_data
- res_data  out  128  ciphertext (core_out passed through)
- inflight  out  CNT_W  blocks issued but not yet returned
- idle  out  1  high when inflight==0 and no reqN_valid is high

Behaviour:
- Reset: one cycle of rst high.
  - Cleared: req0_ready/req1_ready=0, res_valid=0, res_id=0, inflight=0, idle=1, rr pointer=0 (port 0 favoured), tag pipeline all invalid.
  - core_state/core_key reset to 0.
- Reset mid-operation: all in-flight tags are discarded. The core's contents are not cleared, but no res_valid is produced for blocks issued before reset.
- Arbitration (combinational in cycle t):
  - Only one valid: that port is granted.
  - Both valid: grant goes to the port selected by rr. After a grant, rr = 1 − granted ID.
  - reqN_ready = grant to port N. Ready is never high without valid; the handshake completes in the same cycle. No backpressure from the core.
- Issue:
  - On a grant in cycle t, the granted state/key are registered into core_state/core_key at the end of t and held until the next grant.
  - tag[0] <= {1, ID}; with no grant, tag[0] <= {0, x}.
  - Throughput: one block per cycle, sustained.
- Tag pipeline:
  - LATENCY+1 stages of {valid, id}; shifts every cycle.
  - Output stage drives res_valid and res_id.
  - Result for a grant in cycle t appears in cycle t+1+LATENCY (22 cycles with default).
- Result:
  - res_data = core_out unconditionally. Consumers must qualify it with res_valid.
  - No stall capability; the consumer must accept every result.
- inflight:
  - +1 on grant, −1 on res_valid, unchanged when both occur in the same cycle.
  - Maximum value is LATENCY+1; it never wraps.
- Ordering: results return in issue order; requests from a single port are never reordered.

Decomposition:
- Shared package aes_sched_pkg:
  - AES_BLK_W=128, AES_LATENCY=21.
  - Requester ID type (1 bit).
  - Tag struct {valid, id}.
- One natural sub-module: aes_tag_pipe (parameterised-depth valid/ID shift register with synchronous reset), reusable for other pipelined crypto cores.
- Arbiter is inline (two ports).

Test Plan:
- Reset/idle: rst high 2 cycles, no requests -> all outputs 0 except idle=1; res_valid stays 0 for 50 cycles.
- Single request, FIPS-197 vector:
  - Stimulus: req0 issues state 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f in cycle 10.
  - Required: req0_ready=1 in cycle 10; res_valid=1, res_id=0, res_data 69c4e0d86a7b0430d8cdb78070b4c55a in cycle 32; inflight=1 in cycles 11..32, 0 in cycle 33.
- Contention: both valid continuously for 8 cycles after reset -> grants 0,1,0,1,0,1,0,1; results return 22 cycles later with res_id alternating 0,1,… in the same order.
- Back-to-back single port: req1 valid for 30 consecutive cycles -> req1_ready high every cycle; inflight saturates at 22 and holds (simultaneous issue and retire); 30 consecutive res_valid with res_id=1.
- Reset mid-flight: issue 5 blocks, assert rst 3 cycles later -> no res_valid in the following 25 cycles; inflight=0 and rr=0 after reset.
- rr fairness after idle: req0 alone granted, then both valid -> port 1 granted first.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES request scheduler and its tag pipeline.
package aes_sched_pkg;

  localparam int AES_BLK_W   = 128;
  localparam int AES_LATENCY = 21;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/aes_sched_tag_pipe.sv
// Valid/ID shift register that travels alongside a fixed-latency pipelined core.
module aes_tag_pipe
  import aes_sched_pkg::*;
#(
  parameter int DEPTH = AES_LATENCY + 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t head,
  output tag_t tail
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= head;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[DEPTH-1];

endmodule

// File: rtl/aes_req_scheduler.sv
// Round-robin sharing of one pipelined AES-128 core between two requesters,
// with each ciphertext returned tagged by the requester that issued it.
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int LATENCY = AES_LATENCY,
  parameter int CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req0_state,
  input  logic [AES_BLK_W-1:0] req0_key,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req1_state,
  input  logic [AES_BLK_W-1:0] req1_key,
  output logic [AES_BLK_W-1:0] core_state,
  output logic [AES_BLK_W-1:0] core_key,
  input  logic [AES_BLK_W-1:0] core_out,
  output logic                 res_valid,
  output logic                 res_id,
  output logic [AES_BLK_W-1:0] res_data,
  output logic [CNT_W-1:0]     inflight,
  output logic                 idle
);

  req_id_t rr;
  logic    grant;
  req_id_t grant_id;
  tag_t    tag_head;
  tag_t    tag_tail;

  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant    = 1'b1;
        grant_id = rr;
      end else if (req0_valid) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (req1_valid) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  assign req0_ready = grant && (grant_id == 1'b0);
  assign req1_ready = grant && (grant_id == 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr         <= 1'b0;
      core_state <= '0;
      core_key   <= '0;
    end else if (grant) begin
      rr         <= ~grant_id;
      core_state <= grant_id ? req1_state : req0_state;
      core_key   <= grant_id ? req1_key   : req0_key;
    end
  end

  assign tag_head.valid = grant;
  assign tag_head.id    = grant_id;

  // One extra stage covers the core_state/core_key input register.
  aes_tag_pipe #(
    .DEPTH(LATENCY + 1)
  ) u_tag_pipe (
    .clk (clk),
    .rst (rst),
    .head(tag_head),
    .tail(tag_tail)
  );

  // Gated by rst so blocks issued before a reset never surface.
  assign res_valid = tag_tail.valid && !rst;
  assign res_id    = res_valid ? tag_tail.id : 1'b0;
  assign res_data  = core_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({grant, res_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign idle = (inflight == '0) && !req0_valid && !req1_valid;

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Randomised scoreboard bench for aes_req_scheduler with a stand-in AES core model.
module tb_aes_req_scheduler;

  localparam int LAT = 21;
  localparam int CW  = 5;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [127:0]  req0_state = '0, req0_key = '0, req1_state = '0, req1_key = '0;
  logic [127:0]  core_state, core_key, core_out;
  logic          res_valid, res_id;
  logic [127:0]  res_data;
  logic [CW-1:0] inflight;
  logic          idle;

  aes_req_scheduler #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_state(req0_state), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_state(req1_state), .req1_key(req1_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  // Stand-in core: known-answer for the FIPS-197 vector, a keyed scramble otherwise.
  function automatic logic [127:0] enc(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {s[63:0], s[127:64]} ^ k ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  logic [127:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= enc(core_state, core_key);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-1];

  typedef struct {
    logic         id;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   issued = 0;
  int   retired = 0;
  int   inflight_snap = 0;
  int   peak = 0;
  bit   checking = 0;
  logic rr_m = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (checking) begin
      inflight_snap = issued - retired;
      check("inflight", 128'(inflight), 128'(inflight_snap));
      if (int'(inflight) > peak) peak = int'(inflight);
    end
  end

  // Issue monitor: reference arbitration, pushes expected results.
  always @(negedge clk) begin
    if (checking) begin
      logic g;
      logic gid;
      g   = 1'b0;
      gid = 1'b0;
      if (rst) begin
        exp_q.delete();
        issued = 0;
        rr_m   = 1'b0;
      end else if (req0_valid || req1_valid) begin
        g   = 1'b1;
        gid = (req0_valid && req1_valid) ? rr_m : (req1_valid ? 1'b1 : 1'b0);
      end
      check("req0_ready", 128'(req0_ready), 128'(g && gid == 1'b0));
      check("req1_ready", 128'(req1_ready), 128'(g && gid == 1'b1));
      check("idle", 128'(idle), 128'(inflight_snap == 0 && !req0_valid && !req1_valid));
      if (g) begin
        exp_t e;
        e.id   = gid;
        e.data = gid ? enc(req1_state, req1_key) : enc(req0_state, req0_key);
        e.due  = cyc + LAT + 1;
        exp_q.push_back(e);
        issued++;
        rr_m = ~gid;
      end
    end
  end

  // Result monitor: pops and compares whenever the DUT presents a result.
  always @(negedge clk) begin
    if (checking) begin
      if (rst) begin
        retired = 0;
        check("res_valid_in_reset", 128'(res_valid), 128'(0));
      end else if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("res_valid_unexpected", 128'(res_valid), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_id", 128'(res_id), 128'(e.id));
          check("res_data", res_data, e.data);
          check("res_cycle", 128'(cyc), 128'(e.due));
          retired++;
        end
      end
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input logic v0, input logic v1);
    @(posedge clk); #2;
    rst        = 1'b0;
    req0_valid = v0;
    req1_valid = v1;
    req0_state = rand128();
    req0_key   = rand128();
    req1_state = rand128();
    req1_key   = rand128();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 checking = 1;
    @(negedge clk);
    check("rst_req0_ready", 128'(req0_ready), 128'(0));
    check("rst_req1_ready", 128'(req1_ready), 128'(0));
    check("rst_res_valid", 128'(res_valid), 128'(0));
    check("rst_res_id", 128'(res_id), 128'(0));
    check("rst_inflight", 128'(inflight), 128'(0));
    check("rst_idle", 128'(idle), 128'(1));
    check("rst_core_state", core_state, 128'(0));
    check("rst_core_key", core_key, 128'(0));

    repeat (50) drive(1'b0, 1'b0);

    @(posedge clk); #2;
    req0_valid = 1'b1;
    req0_state = FIPS_PT;
    req0_key   = FIPS_KEY;
    repeat (30) drive(1'b0, 1'b0);

    repeat (8) drive(1'b1, 1'b1);
    repeat (30) drive(1'b0, 1'b0);

    peak = 0;
    repeat (30) drive(1'b0, 1'b1);
    repeat (30) drive(1'b0, 1'b0);
    check("inflight_peak", 128'(peak), 128'(LAT + 1));

    drive(1'b1, 1'b0);
    repeat (2) drive(1'b1, 1'b1);
    repeat (30) drive(1'b0, 1'b0);

    repeat (5) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    pulse_reset();
    repeat (25) drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    repeat (30) drive(1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) pulse_reset();
      else drive(1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    repeat (30) drive(1'b0, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
